// File: rtl/password_sequence_checker.sv
// Serial keypad code checker: compares DIGITS keyed digits against a stored code and locks down
// after MAX_FAIL consecutive failures. Define PWCHK_ADMIN_CODE_EN to add the hardwired admin code path.
module password_sequence_checker #(
    parameter  int DIGITS   = 4,
    parameter  int DIGIT_W  = 4,
    parameter  int MAX_FAIL = 3,
    localparam int ADDR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int FAIL_W   = $clog2(MAX_FAIL + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               entry_clr,
    input  logic               lock_clr,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DIGIT_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  digit_idx,
    output logic [FAIL_W-1:0]  fail_cnt,
    output logic               error_light,
    output logic               unlock_light,
    output logic               lock_down,
    output logic [1:0]         state_dbg
);

    // Handshake: digit_valid is a strobe with no back-pressure; every cycle it is high carries
    // one digit, and it is consumed that same cycle unless lock_clr or entry_clr takes priority.

    typedef enum logic [1:0] {
        S_ENTRY  = 2'd0,
        S_ERROR  = 2'd1,
        S_UNLOCK = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DIGITS - 1);
    localparam logic [FAIL_W:0]   MAX_EXT  = (FAIL_W + 1)'(MAX_FAIL);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic                mis, mis_n;
    logic [FAIL_W-1:0]   fail, fail_n;

    logic                last;
    logic                user_miss;
    logic [FAIL_W:0]     fail_inc;
    logic                admin_hit;

    assign last      = (idx == LAST_IDX);
    assign user_miss = mis | (digit != rd_data);
    assign fail_inc  = {1'b0, fail} + (FAIL_W + 1)'(1);

`ifdef PWCHK_ADMIN_CODE_EN
    logic                adm, adm_n;
    logic [DIGIT_W-1:0]  admin_digit;
    logic                admin_miss;

    // Admin code is 0,1,..,DIGITS-2 followed by 9.
    assign admin_digit = last ? DIGIT_W'(9) : DIGIT_W'(idx);
    assign admin_miss  = adm | (digit != admin_digit);
    assign admin_hit   = last & ~admin_miss;

    always_comb begin
        adm_n = adm;
        if (lock_clr || (entry_clr && state != S_LOCKED)) begin
            adm_n = 1'b0;
        end else if (digit_valid && state != S_UNLOCK) begin
            adm_n = last ? 1'b0 : admin_miss;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            adm <= 1'b0;
        end else begin
            adm <= adm_n;
        end
    end
`else
    assign admin_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_ENTRY;
            idx   <= '0;
            mis   <= 1'b0;
            fail  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            mis   <= mis_n;
            fail  <= fail_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        mis_n   = mis;
        fail_n  = fail;

        if (lock_clr) begin
            state_n = S_ENTRY;
            idx_n   = '0;
            mis_n   = 1'b0;
            fail_n  = '0;
        end else if (entry_clr && state != S_LOCKED) begin
            state_n = S_ENTRY;
            idx_n   = '0;
            mis_n   = 1'b0;
        end else if (digit_valid) begin
            case (state)
                // idx is always 0 in S_ERROR, so a digit there starts a fresh entry.
                S_ENTRY, S_ERROR: begin
                    if (last) begin
                        idx_n = '0;
                        mis_n = 1'b0;
                        if (admin_hit || !user_miss) begin
                            state_n = S_UNLOCK;
                            fail_n  = '0;
                        end else if (fail_inc < MAX_EXT) begin
                            state_n = S_ERROR;
                            fail_n  = fail_inc[FAIL_W-1:0];
                        end else begin
                            state_n = S_LOCKED;
                            fail_n  = FAIL_W'(MAX_FAIL);
                        end
                    end else begin
                        state_n = S_ENTRY;
                        idx_n   = idx + ADDR_W'(1);
                        mis_n   = user_miss;
                    end
                end
`ifdef PWCHK_ADMIN_CODE_EN
                S_LOCKED: begin
                    if (last) begin
                        idx_n = '0;
                        if (admin_hit) begin
                            state_n = S_UNLOCK;
                            fail_n  = '0;
                        end
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign rd_addr      = idx;
    assign digit_idx    = idx;
    assign fail_cnt     = fail;
    assign error_light  = (state == S_ERROR);
    assign unlock_light = (state == S_UNLOCK);
    assign lock_down    = (state == S_LOCKED);
    assign state_dbg    = state;

endmodule

// File: tb/tb_password_sequence_checker.sv
// Scoreboard bench for password_sequence_checker: directed scenarios plus randomized keying,
// checked against a code-level reference model that judges whole entered codes.
`timescale 1ns/1ps
module tb_password_sequence_checker;

    localparam int DIGITS   = 4;
    localparam int DIGIT_W  = 4;
    localparam int MAX_FAIL = 3;
    localparam int ADDR_W   = 2;
    localparam int FAIL_W   = 2;
    localparam int EXP_W    = 2 * ADDR_W + FAIL_W + 3;

    // ---------------- clock / reset ----------------
    logic               CLK = 1'b0;
    logic               RST;
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               entry_clr;
    logic               lock_clr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DIGIT_W-1:0] rd_data;
    logic [ADDR_W-1:0]  digit_idx;
    logic [FAIL_W-1:0]  fail_cnt;
    logic               error_light;
    logic               unlock_light;
    logic               lock_down;
    logic [1:0]         state_dbg;

    always #5 CLK = ~CLK;

    logic [DIGIT_W-1:0] stored [DIGITS];
    assign rd_data = stored[rd_addr];

    password_sequence_checker #(
        .DIGITS   (DIGITS),
        .DIGIT_W  (DIGIT_W),
        .MAX_FAIL (MAX_FAIL)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .entry_clr    (entry_clr),
        .lock_clr     (lock_clr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .digit_idx    (digit_idx),
        .fail_cnt     (fail_cnt),
        .error_light  (error_light),
        .unlock_light (unlock_light),
        .lock_down    (lock_down),
        .state_dbg    (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int m_keys[$];
    bit m_unlock, m_locked, m_error;
    int m_fail;

    function automatic int admin_code(input int i);
        return (i == DIGITS - 1) ? 9 : i;
    endfunction

    function automatic logic [EXP_W-1:0] model_outputs();
        logic [ADDR_W-1:0] sz;
        sz = ADDR_W'(m_keys.size());
        return {sz, sz, FAIL_W'(m_fail), m_error, m_unlock, m_locked};
    endfunction

    task automatic model_reset();
        m_keys.delete();
        m_unlock = 0;
        m_locked = 0;
        m_error  = 0;
        m_fail   = 0;
    endtask

    task automatic model_step(input bit dv, input int d, input bit ec, input bit lc);
        bit user_ok;
        bit admin_ok;
        if (lc) begin
            model_reset();
        end else if (ec && !m_locked) begin
            m_keys.delete();
            m_unlock = 0;
            m_error  = 0;
        end else if (dv && !m_unlock) begin
            if (m_locked) begin
`ifdef PWCHK_ADMIN_CODE_EN
                m_keys.push_back(d);
                if (m_keys.size() == DIGITS) begin
                    admin_ok = 1;
                    for (int i = 0; i < DIGITS; i++)
                        if (m_keys[i] != admin_code(i)) admin_ok = 0;
                    m_keys.delete();
                    if (admin_ok) begin
                        m_locked = 0;
                        m_unlock = 1;
                        m_fail   = 0;
                    end
                end
`endif
            end else begin
                m_error = 0;
                m_keys.push_back(d);
                if (m_keys.size() == DIGITS) begin
                    user_ok  = 1;
                    admin_ok = 0;
                    for (int i = 0; i < DIGITS; i++)
                        if (m_keys[i] != int'(stored[i])) user_ok = 0;
`ifdef PWCHK_ADMIN_CODE_EN
                    admin_ok = 1;
                    for (int i = 0; i < DIGITS; i++)
                        if (m_keys[i] != admin_code(i)) admin_ok = 0;
`endif
                    m_keys.delete();
                    if (user_ok || admin_ok) begin
                        m_unlock = 1;
                        m_fail   = 0;
                    end else begin
                        m_fail++;
                        if (m_fail >= MAX_FAIL) m_locked = 1;
                        else                    m_error  = 1;
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_exp;
    logic [EXP_W-1:0] mon_got;

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {rd_addr, digit_idx, fail_cnt, error_light, unlock_light, lock_down};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t got {addr,idx,fail,err,unl,lock}=%b required=%b",
                         $time, mon_got, mon_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit dv, input int d, input bit ec, input bit lc);
        @(negedge CLK);
        digit_valid = dv;
        digit       = DIGIT_W'(d);
        entry_clr   = ec;
        lock_clr    = lc;
        model_step(dv, d, ec, lc);
        exp_q.push_back(model_outputs());
        @(posedge CLK);
        #2;
        digit_valid = 1'b0;
        digit       = '0;
        entry_clr   = 1'b0;
        lock_clr    = 1'b0;
    endtask

    task automatic key(input int d);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic press(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b0;
        #2;
        model_reset();
        check("async_reset_idx", 32'(digit_idx), 32'd0);
        check("async_reset_lights", 32'({error_light, unlock_light, lock_down}), 32'd0);
        #1;
        RST = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int sel;
        bit dv, ec, lc;
        int d;

        RST         = 1'b0;
        digit_valid = 1'b0;
        digit       = '0;
        entry_clr   = 1'b0;
        lock_clr    = 1'b0;
        stored      = '{4'd3, 4'd7, 4'd1, 4'd5};
        model_reset();
        #2;
        check("reset_outputs",
              32'({rd_addr, digit_idx, fail_cnt, error_light, unlock_light, lock_down}),
              32'(model_outputs()));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // correct code unlocks one cycle after the last key
        press(3, 7, 1, 5);
        check("unlock_after_code", 32'(unlock_light), 32'd1);
        check("fail_after_unlock", 32'(fail_cnt), 32'd0);

        // digits are ignored while unlocked
        key(3);
        check("unlock_ignores_digit", 32'(digit_idx), 32'd0);

        // wrong second digit only reported after the 4th key
        drive(0, 0, 1, 0);
        key(3); key(0); key(1);
        check("no_early_error", 32'(error_light), 32'd0);
        key(5);
        check("error_after_code", 32'(error_light), 32'd1);
        check("fail_one", 32'(fail_cnt), 32'd1);

        // digit in error state starts a new entry
        key(9);
        check("error_digit_idx", 32'(digit_idx), 32'd1);
        check("error_light_drops", 32'(error_light), 32'd0);
        key(9); key(9); key(9);
        check("fail_two", 32'(fail_cnt), 32'd2);
        press(0, 0, 0, 0);
        check("lockdown", 32'(lock_down), 32'd1);
        check("fail_saturated", 32'(fail_cnt), 32'd3);

        // user code ignored and entry_clr ignored while locked
        press(3, 7, 1, 5);
        check("locked_ignores_code", 32'(lock_down), 32'd1);
        drive(0, 0, 1, 0);
        check("locked_ignores_clr", 32'(lock_down), 32'd1);

        // admin code
        press(0, 1, 2, 9);
`ifdef PWCHK_ADMIN_CODE_EN
        check("admin_unlock", 32'(unlock_light), 32'd1);
        check("admin_lock_released", 32'(lock_down), 32'd0);
        check("admin_fail_cleared", 32'(fail_cnt), 32'd0);
`else
        check("admin_absent_locked", 32'(lock_down), 32'd1);
`endif

        // supervisor clear
        drive(0, 0, 0, 1);
        check("lock_clr_fail", 32'(fail_cnt), 32'd0);
        check("lock_clr_state", 32'(lock_down), 32'd0);

        // abort a partial entry
        key(3); key(7);
        drive(0, 0, 1, 0);
        check("entry_clr_idx", 32'(digit_idx), 32'd0);
        press(3, 7, 1, 5);
        check("unlock_after_abort", 32'(unlock_light), 32'd1);

        // lock_clr wins over entry_clr: the failure count clears too
        drive(0, 0, 1, 0);
        press(1, 1, 1, 1);
        key(3);
        drive(0, 0, 1, 1);
        check("both_clr_fail", 32'(fail_cnt), 32'd0);
        check("both_clr_idx", 32'(digit_idx), 32'd0);

        // async reset mid-entry discards the partial entry
        key(3); key(7);
        pulse_reset();
        press(3, 7, 1, 5);
        check("unlock_after_reset", 32'(unlock_light), 32'd1);

        // randomized keying against a fresh stored code
        drive(0, 0, 0, 1);
        for (int i = 0; i < DIGITS; i++) stored[i] = DIGIT_W'($urandom_range(0, 9));
        drive(0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            r   = $urandom_range(0, 99);
            dv  = (r < 65);
            ec  = ($urandom_range(0, 99) < 5);
            lc  = ($urandom_range(0, 99) < 3);
            sel = $urandom_range(0, 3);
            if (sel <= 1)      d = int'(stored[m_keys.size()]);
            else if (sel == 2) d = admin_code(m_keys.size());
            else               d = $urandom_range(0, 15);
            if (n % 150 == 149) pulse_reset();
            else                drive(dv, d, ec, lc);
        end

        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
